uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo_pkg.sv | 20 ++
 rtl/uart_tx_fifo_byte_fifo.sv | 73 +++++++
 rtl/uart_tx_fifo.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: register offsets,
// STATUS bit positions and the serializer state encoding.
package uart_pkg;

    localparam logic [1:0] UART_TXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

endpackage

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Synchronous byte FIFO. A push while full is accepted only when a pop
// frees a slot in the same cycle; dout is combinational from the read pointer.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_q == (AW+1)'(DEPTH));
    assign empty     = (count_q == (AW+1)'(0));
    assign dout      = mem_q[rd_ptr_q];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Next pointer and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= (AW+1)'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bus register decode, byte FIFO, and a
// baud-timed serializer that drains the FIFO with back-to-back frames.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLOCK = 25000000,
    parameter int BAUD  = 115200,
    parameter int DEPTH = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wren,
    input  logic [1:0] addr,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       tx
);

    localparam int DIV = CLOCK / BAUD;
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] DIV_LAST = BW'(DIV - 1);

    state_e        state_q, state_d;
    logic [BW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;

    logic          push_s, pop_s, ovf_set_s, ovf_clr_s, baud_tc_s;
    logic          full_s, empty_s, busy_s;
    logic [7:0]    fifo_dout_s;
    logic [7:0]    status_s;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (data_i),
        .full  (full_s),
        .empty (empty_s),
        .dout  (fifo_dout_s)
    );

    assign push_s    = wren && (addr == UART_TXDATA);
    assign ovf_clr_s = wren && (addr == UART_STATUS) && data_i[ST_OVF];
    assign ovf_set_s = push_s && full_s && !pop_s;
    assign baud_tc_s = (baud_cnt_q == DIV_LAST);
    assign busy_s    = (state_q != IDLE);
    assign tx        = tx_q;

    // Serializer next state: pop on IDLE or at end of STOP, time bits with baud_cnt.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        pop_s      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_s) begin
                    pop_s      = 1'b1;
                    shreg_d    = fifo_dout_s;
                    baud_cnt_d = BW'(0);
                    bit_cnt_d  = 3'd0;
                    state_d    = START;
                end else begin
                    state_d    = IDLE;
                end
            end
            START: begin
                if (baud_tc_s) begin
                    baud_cnt_d = BW'(0);
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_tc_s) begin
                    baud_cnt_d = BW'(0);
                    shreg_d    = {1'b0, shreg_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_tc_s) begin
                    baud_cnt_d = BW'(0);
                    if (!empty_s) begin
                        pop_s     = 1'b1;
                        shreg_d   = fifo_dout_s;
                        bit_cnt_d = 3'd0;
                        state_d   = START;
                    end else begin
                        state_d   = IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level follows the state being entered, so tx is a clean flop output.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // Sticky overflow: a set in the same cycle as a clear wins.
    always_comb begin
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Serializer, line and overflow registers; reset aborts any frame in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            baud_cnt_q <= BW'(0);
            bit_cnt_q  <= 3'd0;
            shreg_q    <= 8'h00;
            tx_q       <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tx_q       <= tx_d;
            ovf_q      <= ovf_d;
        end
    end

    // Register read decode; only STATUS returns non-zero data.
    always_comb begin
        status_s         = 8'h00;
        status_s[ST_FULL]  = full_s;
        status_s[ST_EMPTY] = empty_s;
        status_s[ST_BUSY]  = busy_s;
        status_s[ST_OVF]   = ovf_q;
        case (addr)
            UART_STATUS: data_o = status_s;
            default:     data_o = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with DIV=16, DEPTH=4. Inputs change on the
// falling edge; cycle N is the clock period observed at the Nth falling edge
// after the first write of a scenario.
module tb_uart_tx_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wren  = 1'b0;
    logic [1:0] addr  = 2'd1;
    logic [7:0] data_i = 8'h00;
    logic [7:0] data_o;
    logic       tx;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [7:0] rx_q [$];

    uart_tx_fifo #(.CLOCK(16), .BAUD(1), .DEPTH(4)) dut (
        .clock  (clock),
        .reset  (reset),
        .wren   (wren),
        .addr   (addr),
        .data_i (data_i),
        .data_o (data_o),
        .tx     (tx)
    );

    always #5 clock = ~clock;

    // Line receiver: samples each bit in its middle and collects bytes.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clock);
            if (tx === 1'b0) begin
                repeat (8) @(negedge clock);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clock);
                    b[i] = tx;
                end
                repeat (16) @(negedge clock);
                rx_q.push_back(b);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        cyc++;
    endtask

    task automatic goto_cyc(input int n);
        while (cyc < n) tick();
    endtask

    task automatic drive(input logic w, input logic [1:0] a, input logic [7:0] d);
        wren = w; addr = a; data_i = d;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #8;
        n_cmp++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_cmp++;
        if (data_o !== 8'h02) begin n_fail++; $display("FAIL reset_status: got %h want 02", data_o); end
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        n_cmp++;
        if (data_o !== 8'h02) begin n_fail++; $display("FAIL post_reset_status: got %h want 02", data_o); end
    endtask

    task automatic test_single();
        rx_q.delete();
        tick(); cyc = 0;
        drive(1'b1, 2'd0, 8'h55);
        n_cmp++;
        if (data_o !== 8'h00) begin n_fail++; $display("FAIL txdata_read: got %h want 00", data_o); end
        tick(); drive(1'b0, 2'd1, 8'h00);
        n_cmp++;
        if (data_o !== 8'h00 || tx !== 1'b1) begin n_fail++; $display("FAIL single_c1: status %h tx %b want 00/1", data_o, tx); end
        tick();
        n_cmp++;
        if (tx !== 1'b0 || data_o !== 8'h06) begin n_fail++; $display("FAIL single_start: tx %b status %h want 0/06", tx, data_o); end
        for (int i = 0; i < 8; i++) begin
            goto_cyc(18 + 16 * i);
            n_cmp++;
            if (tx !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL single_bit%0d: got %b", i, tx); end
        end
        goto_cyc(161);
        n_cmp++;
        if (tx !== 1'b1 || data_o !== 8'h06) begin n_fail++; $display("FAIL single_stop_end: tx %b status %h want 1/06", tx, data_o); end
        goto_cyc(162);
        n_cmp++;
        if (data_o !== 8'h02) begin n_fail++; $display("FAIL single_idle: status %h want 02", data_o); end
        goto_cyc(180);
        n_cmp++;
        if (rx_q.size() !== 1 || rx_q[0] !== 8'h55) begin n_fail++; $display("FAIL single_rx: %0d bytes, first %h want 1/55", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        exp_b = '{8'h00, 8'hFF, 8'hA5};
        rx_q.delete();
        tick(); cyc = 0;
        drive(1'b1, 2'd0, 8'h00);
        tick(); drive(1'b1, 2'd0, 8'hFF);
        tick(); drive(1'b1, 2'd0, 8'hA5);
        tick(); drive(1'b0, 2'd1, 8'h00);
        goto_cyc(161);
        n_cmp++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL b2b_stop1: got %b want 1", tx); end
        goto_cyc(162);
        n_cmp++;
        if (tx !== 1'b0 || data_o !== 8'h04) begin n_fail++; $display("FAIL b2b_start2: tx %b status %h want 0/04", tx, data_o); end
        goto_cyc(322);
        n_cmp++;
        if (tx !== 1'b0 || data_o !== 8'h06) begin n_fail++; $display("FAIL b2b_start3: tx %b status %h want 0/06", tx, data_o); end
        goto_cyc(481);
        n_cmp++;
        if (tx !== 1'b1 || data_o !== 8'h06) begin n_fail++; $display("FAIL b2b_last_stop: tx %b status %h want 1/06", tx, data_o); end
        goto_cyc(482);
        n_cmp++;
        if (data_o !== 8'h02) begin n_fail++; $display("FAIL b2b_empty: status %h want 02", data_o); end
        goto_cyc(500);
        n_cmp++;
        if (rx_q.size() !== 3) begin
            n_fail++; $display("FAIL b2b_rx_count: got %0d want 3", rx_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (rx_q[k] !== exp_b[k]) begin n_fail++; $display("FAIL b2b_rx%0d: got %h want %h", k, rx_q[k], exp_b[k]); end
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_b [6];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h3C};
        rx_q.delete();
        tick(); cyc = 0;
        drive(1'b1, 2'd0, 8'h11);
        tick(); drive(1'b1, 2'd0, 8'h22);
        tick(); drive(1'b1, 2'd0, 8'h33);
        tick(); drive(1'b1, 2'd0, 8'h44);
        tick(); drive(1'b1, 2'd0, 8'h5A);
        tick(); drive(1'b0, 2'd1, 8'h00);
        n_cmp++;
        if (data_o !== 8'h05) begin n_fail++; $display("FAIL ovf_full: status %h want 05", data_o); end
        tick(); drive(1'b1, 2'd0, 8'h77);
        tick(); drive(1'b1, 2'd1, 8'h08);
        n_cmp++;
        if (data_o !== 8'h0D) begin n_fail++; $display("FAIL ovf_set: status %h want 0D", data_o); end
        tick(); drive(1'b0, 2'd1, 8'h00);
        n_cmp++;
        if (data_o !== 8'h05) begin n_fail++; $display("FAIL ovf_clear: status %h want 05", data_o); end
        goto_cyc(161);
        drive(1'b1, 2'd0, 8'h3C);
        tick(); drive(1'b0, 2'd1, 8'h00);
        n_cmp++;
        if (data_o !== 8'h05) begin n_fail++; $display("FAIL push_pop_full: status %h want 05", data_o); end
        goto_cyc(1000);
        n_cmp++;
        if (data_o !== 8'h02) begin n_fail++; $display("FAIL ovf_drained: status %h want 02", data_o); end
        n_cmp++;
        if (rx_q.size() !== 6) begin
            n_fail++; $display("FAIL ovf_rx_count: got %0d want 6", rx_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                n_cmp++;
                if (rx_q[k] !== exp_b[k]) begin n_fail++; $display("FAIL ovf_rx%0d: got %h want %h", k, rx_q[k], exp_b[k]); end
            end
        end
    endtask

    task automatic test_unmapped();
        logic line_ok;
        rx_q.delete();
        tick(); cyc = 0;
        drive(1'b1, 2'd2, 8'hFF);
        n_cmp++;
        if (data_o !== 8'h00) begin n_fail++; $display("FAIL unmapped_rd2: got %h want 00", data_o); end
        tick(); drive(1'b1, 2'd3, 8'h12);
        n_cmp++;
        if (data_o !== 8'h00) begin n_fail++; $display("FAIL unmapped_rd3: got %h want 00", data_o); end
        tick(); drive(1'b0, 2'd1, 8'h00);
        n_cmp++;
        if (data_o !== 8'h02) begin n_fail++; $display("FAIL unmapped_status: got %h want 02", data_o); end
        line_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (tx !== 1'b1) line_ok = 1'b0;
        end
        n_cmp++;
        if (line_ok !== 1'b1 || rx_q.size() !== 0) begin n_fail++; $display("FAIL unmapped_line: idle %b bytes %0d want 1/0", line_ok, rx_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        logic line_ok;
        tick(); cyc = 0;
        drive(1'b1, 2'd0, 8'hAA);
        tick(); drive(1'b1, 2'd0, 8'h33);
        tick(); drive(1'b0, 2'd1, 8'h00);
        goto_cyc(20);
        n_cmp++;
        if (tx !== 1'b0) begin n_fail++; $display("FAIL midframe_pre: tx %b want 0", tx); end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (tx !== 1'b1) begin n_fail++; $display("FAIL midframe_abort: tx %b want 1", tx); end
        tick(); tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (data_o !== 8'h02) begin n_fail++; $display("FAIL midframe_status: got %h want 02", data_o); end
        line_ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (tx !== 1'b1) line_ok = 1'b0;
        end
        n_cmp++;
        if (line_ok !== 1'b1) begin n_fail++; $display("FAIL midframe_discard: line idle %b want 1", line_ok); end
        rx_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_unmapped();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
